// File: rtl/fetch_aligner.sv
// Instruction-fetch aligner: issues word-aligned fetches, buffers returned
// halfwords in a 3-entry queue and presents one 16- or 32-bit instruction
// per cycle with its PC. Any redirect flushes the queue. A response that is
// still in flight when the redirect arrives is discarded.
module fetch_aligner #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_pc,
   output logic              out_is_compressed
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [15:0]       hw_q [3];
   logic [15:0]       hw_d [3];
   logic [1:0]        count_q, count_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic              drop_low_q, drop_low_d;

   logic              head_comp;
   logic              accept;
   logic              push;
   logic [1:0]        pop_n;
   logic [1:0]        rem;
   logic [2:0]        src;

   // Issue side and handshake qualifiers, all decoded from registered state
   always_comb begin
      head_comp         = (hw_q[0][1:0] != 2'b11);
      out_valid         = rst && (head_comp ? (count_q >= 2'd1) : (count_q >= 2'd2));
      out_inst          = head_comp ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
      out_is_compressed = head_comp;
      out_pc            = out_pc_q;
      // Requesting only at count<=1 leaves room for a full word on return
      mem_req           = rst && (state_q == S_IDLE) && (count_q <= 2'd1) && !redirect;
      mem_addr          = fetch_addr_q;
      accept            = out_valid && out_ready && !redirect;
      push              = rst && (state_q == S_WAIT) && mem_rvalid && !redirect;
      pop_n             = accept ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
      rem               = count_q - pop_n;
   end

   // Halfword queue: pop from the head first, then append behind the remainder
   always_comb begin
      src = 3'd0;
      for (int i = 0; i < 3; i++) begin
         src     = 3'(i) + {1'b0, pop_n};
         hw_d[i] = (src < 3'd3) ? hw_q[src[1:0]] : hw_q[i];
         if (push && (3'(i) == {1'b0, rem}))
            hw_d[i] = drop_low_q ? mem_rdata[31:16] : mem_rdata[15:0];
         if (push && !drop_low_q && (3'(i) == {1'b0, rem} + 3'd1))
            hw_d[i] = mem_rdata[31:16];
      end
      if (redirect)
         count_d = 2'd0;
      else if (push)
         count_d = rem + (drop_low_q ? 2'd1 : 2'd2);
      else
         count_d = rem;
   end

   // Fetch FSM, fetch pointer and PC bookkeeping; redirect overrides everything
   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      drop_low_d   = drop_low_q;
      out_pc_d     = out_pc_q;
      case (state_q)
         S_IDLE:  if (mem_req) state_d = S_WAIT;
         S_WAIT: begin
            if (mem_rvalid)    state_d = S_IDLE;
            else if (redirect) state_d = S_DRAIN;
         end
         S_DRAIN: if (mem_rvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (mem_req)
         fetch_addr_d = fetch_addr_q + ADDR_W'(4);
      if (push && drop_low_q)
         drop_low_d = 1'b0;
      if (accept)
         out_pc_d = out_pc_q + (head_comp ? ADDR_W'(2) : ADDR_W'(4));
      if (redirect) begin
         fetch_addr_d = {redirect_pc[ADDR_W-1:2], 2'b00};
         drop_low_d   = redirect_pc[1];
         out_pc_d     = redirect_pc;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         count_q      <= 2'd0;
         fetch_addr_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
         drop_low_q   <= RESET_PC[1];
         out_pc_q     <= RESET_PC;
         for (int i = 0; i < 3; i++) hw_q[i] <= 16'h0000;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         fetch_addr_q <= fetch_addr_d;
         drop_low_q   <= drop_low_d;
         out_pc_q     <= out_pc_d;
         for (int i = 0; i < 3; i++) hw_q[i] <= hw_d[i];
      end
   end
endmodule
